// File: rtl/syrup_port_arbiter.sv
// syrup_port_arbiter: shares one Syrup memory port among NUM_REQ requesters.
// Round-robin grant, registered memory command, read data routed back by id.
// Optional build macro SYRUP_ARB_LOCK_EN adds a per-requester lock input that
// lets the previous owner keep the port for up to MAX_LOCK consecutive grants.
module syrup_port_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned W_A        = 24,
   parameter int unsigned W_D        = 32,
   parameter int unsigned RD_LATENCY = 1
`ifdef SYRUP_ARB_LOCK_EN
   ,
   parameter int unsigned MAX_LOCK   = 4
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_we,
   input  logic [NUM_REQ*W_A-1:0] req_addr,
   input  logic [NUM_REQ*W_D-1:0] req_d,
`ifdef SYRUP_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]     req_lock,
`endif
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     resp_valid,
   output logic [W_D-1:0]         resp_q,
   output logic [W_A-1:0]         mem_addr,
   output logic [W_D-1:0]         mem_d,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [W_D-1:0]         mem_q,
   output logic                   busy
);

   localparam int unsigned W_ID = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Pipeline stages other than the last one; used to look ahead for busy.
   localparam logic [RD_LATENCY-1:0] EARLY_MASK =
      RD_LATENCY'((64'(1) << (RD_LATENCY - 1)) - 64'(1));

   logic [W_ID-1:0]    last;
   logic [W_ID-1:0]    rr_idx;
   logic [W_ID-1:0]    rr_sel;
   logic [NUM_REQ-1:0] rr_grant;
   logic [W_ID-1:0]    sel;
   logic [NUM_REQ-1:0] grant;
   logic               accept;
   logic               rd_issue;
   logic [W_A-1:0]     sel_addr;
   logic [W_D-1:0]     sel_d;

   logic [W_ID-1:0]       mem_id;
   logic [RD_LATENCY-1:0] pipe_vld;
   logic [W_ID-1:0]       pipe_id [RD_LATENCY];
   logic [NUM_REQ-1:0]    resp_hot;

   // Round-robin scan starting one past the last accepted requester.
   always_comb begin
      rr_grant = '0;
      rr_sel   = '0;
      rr_idx   = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         rr_idx = W_ID'((32'(last) + off) % NUM_REQ);
         if (rr_grant == '0 && req_valid[rr_idx]) begin
            rr_grant[rr_idx] = 1'b1;
            rr_sel           = rr_idx;
         end
      end
   end

`ifdef SYRUP_ARB_LOCK_EN
   localparam int unsigned W_CNT = $clog2(MAX_LOCK + 1);

   logic [W_CNT-1:0] lock_cnt;
   logic             lock_win;

   // Previous owner keeps the port while it holds lock and has budget left.
   always_comb begin
      lock_win = (lock_cnt != '0) && (lock_cnt < W_CNT'(MAX_LOCK)) &&
                 req_valid[last] && req_lock[last];
   end

   // Final grant: lock winner first, otherwise round-robin.
   always_comb begin
      grant = '0;
      sel   = rr_sel;
      if (enable) begin
         if (lock_win) begin
            grant[last] = 1'b1;
            sel         = last;
         end else begin
            grant = rr_grant;
         end
      end
   end

   // Consecutive-grant counter for the current owner; cleared on idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
      end else if (!accept) begin
         lock_cnt <= '0;
      end else if (sel == last && lock_cnt != '0 && lock_cnt < W_CNT'(MAX_LOCK)) begin
         lock_cnt <= lock_cnt + W_CNT'(1);
      end else begin
         lock_cnt <= W_CNT'(1);
      end
   end
`else
   // Final grant: pure round-robin gated by enable.
   always_comb begin
      grant = enable ? rr_grant : '0;
      sel   = rr_sel;
   end
`endif

   assign req_ready = grant;

   // Accept decode and selected command payload.
   always_comb begin
      accept   = |grant;
      rd_issue = accept & ~req_we[sel];
      sel_addr = req_addr[32'(sel)*W_A +: W_A];
      sel_d    = req_d[32'(sel)*W_D +: W_D];
   end

   // Round-robin pointer follows the accepted requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= W_ID'(NUM_REQ - 1);
      end else if (accept) begin
         last <= sel;
      end
   end

   // Registered memory command; address/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr <= '0;
         mem_d    <= '0;
         mem_we   <= 1'b0;
         mem_re   <= 1'b0;
         mem_id   <= '0;
      end else begin
         mem_we <= accept & req_we[sel];
         mem_re <= rd_issue;
         if (accept) begin
            mem_addr <= sel_addr;
            mem_d    <= sel_d;
            mem_id   <= sel;
         end
      end
   end

   // Read tracking pipeline carries {valid,id} until memory data is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int unsigned k = 0; k < RD_LATENCY; k++) begin
            pipe_id[k] <= '0;
         end
      end else begin
         pipe_vld[0] <= mem_re;
         pipe_id[0]  <= mem_id;
         for (int unsigned k = 1; k < RD_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_id[k]  <= pipe_id[k-1];
         end
      end
   end

   // One-hot id of the read whose data is on mem_q this cycle.
   always_comb begin
      resp_hot = '0;
      resp_hot[pipe_id[RD_LATENCY-1]] = 1'b1;
   end

   // Capture read data and pulse the owning requester's valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= '0;
         resp_q     <= '0;
      end else begin
         resp_valid <= pipe_vld[RD_LATENCY-1] ? resp_hot : '0;
         if (pipe_vld[RD_LATENCY-1]) begin
            resp_q <= mem_q;
         end
      end
   end

   // Busy mirrors next-cycle occupancy of the MEM_RE stage and the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
      end else begin
         busy <= rd_issue | mem_re | (|(pipe_vld & EARLY_MASK));
      end
   end

endmodule
